// File: rtl/stack_rpn_controller_if.sv
// stack_rpn_controller_if: token handshake, stack command port and status outputs of stack_rpn_controller.
interface stack_rpn_controller_if;
    logic       TOKEN_VALID;
    logic       TOKEN_KIND;
    logic [3:0] TOKEN_DATA;
    logic       TOKEN_READY;
    logic [1:0] S_COMMAND;
    logic [2:0] S_INDEX;
    logic [3:0] S_I_DATA;
    logic [3:0] S_O_DATA;
    logic [3:0] RESULT;
    logic       RESULT_VALID;
    logic       ERROR;
    logic [2:0] DEPTH;
    modport master (
        input  TOKEN_VALID, TOKEN_KIND, TOKEN_DATA, S_O_DATA,
        output TOKEN_READY, S_COMMAND, S_INDEX, S_I_DATA, RESULT, RESULT_VALID, ERROR, DEPTH
    );
    modport slave (
        output TOKEN_VALID, TOKEN_KIND, TOKEN_DATA, S_O_DATA,
        input  TOKEN_READY, S_COMMAND, S_INDEX, S_I_DATA, RESULT, RESULT_VALID, ERROR, DEPTH
    );
endinterface

// File: rtl/stack_rpn_controller.sv
// stack_rpn_controller: RPN token sequencer driving stack_structural_lite with 4-bit arithmetic.
// Define STACK_RPN_DUP_EN to make opcode 5 a DUP; otherwise it is rejected as illegal.
module stack_rpn_controller #(
    parameter int DEPTH_MAX = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    stack_rpn_controller_if.master bus
);
    localparam logic [2:0] DMAX = 3'(DEPTH_MAX);
    localparam logic [1:0] CMD_NOP = 2'b00, CMD_PUSH = 2'b01, CMD_POP = 2'b10, CMD_GET = 2'b11;
    typedef enum logic [2:0] {
        IDLE = 3'd0, PUSH_OPND = 3'd1, POP_A = 3'd2, POP_B = 3'd3, CAP_B = 3'd4, PUSH_RES = 3'd5
`ifdef STACK_RPN_DUP_EN
        , GET_TOP = 3'd6, CAP_TOP = 3'd7
`endif
    } state_t;
    state_t     state_q, state_d;
    logic [3:0] a_q, a_d, b_q, b_d, result_q, result_d, alu, i_data;
    logic [2:0] op_q, op_d, depth_q, depth_d, index;
    logic [1:0] cmd;
    logic       result_valid_q, result_valid_d, error_q, error_d, accept;
    assign bus.TOKEN_READY  = (state_q == IDLE) && !RESET;
    assign bus.S_COMMAND    = cmd;
    assign bus.S_INDEX      = index;
    assign bus.S_I_DATA     = i_data;
    assign bus.RESULT       = result_q;
    assign bus.RESULT_VALID = result_valid_q;
    assign bus.ERROR        = error_q;
    assign bus.DEPTH        = depth_q;
    assign accept = bus.TOKEN_VALID && bus.TOKEN_READY;
    // a_q is the top (popped first), b_q the element beneath; DUP returns the copied top
    always_comb begin
        alu = op_q == 3'd0 ? b_q + a_q :
              op_q == 3'd1 ? b_q - a_q :
              op_q == 3'd2 ? b_q & a_q :
              op_q == 3'd3 ? b_q | a_q :
              op_q == 3'd4 ? b_q ^ a_q : a_q;
    end
    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        depth_d        = depth_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        error_d        = error_q;
        cmd            = CMD_NOP;
        index          = 3'd0;
        i_data         = 4'd0;
        case (state_q)
            IDLE: if (accept) begin
                if (!bus.TOKEN_KIND) begin
                    a_d = bus.TOKEN_DATA;
                    if (depth_q < DMAX) state_d = PUSH_OPND;
                    else error_d = 1'b1;
                end else begin
                    op_d = bus.TOKEN_DATA[2:0];
                    if (bus.TOKEN_DATA[2:0] <= 3'd4) begin
                        if (depth_q >= 3'd2) state_d = POP_A;
                        else error_d = 1'b1;
                    end
`ifdef STACK_RPN_DUP_EN
                    else if (bus.TOKEN_DATA[2:0] == 3'd5 && depth_q != 3'd0 && depth_q < DMAX) state_d = GET_TOP;
`endif
                    else error_d = 1'b1;
                end
            end
            PUSH_OPND: begin
                cmd     = CMD_PUSH;
                i_data  = a_q;
                depth_d = depth_q + 3'd1;
                state_d = IDLE;
            end
            POP_A: begin
                cmd     = CMD_POP;
                depth_d = depth_q - 3'd1;
                state_d = POP_B;
            end
            POP_B: begin
                cmd     = CMD_POP;
                a_d     = bus.S_O_DATA;
                depth_d = depth_q - 3'd1;
                state_d = CAP_B;
            end
            CAP_B: begin
                b_d     = bus.S_O_DATA;
                state_d = PUSH_RES;
            end
            PUSH_RES: begin
                cmd            = CMD_PUSH;
                i_data         = alu;
                depth_d        = depth_q + 3'd1;
                result_d       = alu;
                result_valid_d = 1'b1;
                state_d        = IDLE;
            end
`ifdef STACK_RPN_DUP_EN
            GET_TOP: begin
                cmd     = CMD_GET;
                state_d = CAP_TOP;
            end
            CAP_TOP: begin
                a_d     = bus.S_O_DATA;
                state_d = PUSH_RES;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= IDLE;
            a_q            <= 4'd0;
            b_q            <= 4'd0;
            op_q           <= 3'd0;
            depth_q        <= 3'd0;
            result_q       <= 4'd0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            depth_q        <= depth_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
        end
    end
endmodule

// File: tb/tb_stack_rpn_controller.sv
// tb_stack_rpn_controller: directed bench for stack_rpn_controller with a behavioural 5-deep stack.
module tb_stack_rpn_controller;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   passed = 0, failed = 0, total = 0, ncmd = 0, base = 0;
    stack_rpn_controller_if bus();
    stack_rpn_controller #(.DEPTH_MAX(5)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
    always #5 CLK = ~CLK;
    logic [3:0] mem [5];
    logic [3:0] o_data = 4'd0;
    int         sp = 0;
    assign bus.S_O_DATA = o_data;
    always @(posedge CLK) begin
        if (RESET) begin
            sp     <= 0;
            o_data <= 4'd0;
        end else begin
            case (bus.S_COMMAND)
                2'b01: if (sp < 5) begin mem[sp] <= bus.S_I_DATA; sp <= sp + 1; end
                2'b10: if (sp > 0) begin o_data <= mem[sp-1]; sp <= sp - 1; end
                2'b11: if (sp > int'(bus.S_INDEX)) o_data <= mem[sp-1-int'(bus.S_INDEX)];
                default: ;
            endcase
        end
    end
    always @(posedge CLK) if (bus.S_COMMAND != 2'b00) ncmd <= ncmd + 1;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    task automatic do_reset();
        RESET = 1'b1;
        bus.TOKEN_VALID = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask
    task automatic send(input logic kind, input logic [3:0] data);
        bus.TOKEN_VALID = 1'b1;
        bus.TOKEN_KIND  = kind;
        bus.TOKEN_DATA  = data;
        tick();
        bus.TOKEN_VALID = 1'b0;
    endtask
    task automatic push(input logic [3:0] v);
        send(1'b0, v);
        tick();
    endtask
    task automatic op_result(input logic [3:0] opc, input logic [3:0] exp, input string tag);
        int n = 0;
        send(1'b1, opc);
        while (bus.RESULT_VALID !== 1'b1 && n < 10) begin tick(); n++; end
        check({tag, "_rv"}, 32'(bus.RESULT_VALID), 1);
        check(tag, 32'(bus.RESULT), 32'(exp));
    endtask
    initial begin
        bus.TOKEN_VALID = 1'b0;
        bus.TOKEN_KIND  = 1'b0;
        bus.TOKEN_DATA  = 4'd0;
        RESET = 1'b1;
        tick();
        check("rst_cmd1", 32'(bus.S_COMMAND), 0);
        check("rst_ready", 32'(bus.TOKEN_READY), 0);
        tick();
        check("rst_cmd2", 32'(bus.S_COMMAND), 0);
        check("rst_outs", {bus.S_INDEX, bus.S_I_DATA, bus.RESULT, bus.RESULT_VALID, bus.ERROR, bus.DEPTH}, 0);
        RESET = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.TOKEN_READY), 1);
        send(1'b0, 4'd3);
        check("push3_cmd", {bus.S_COMMAND, bus.S_I_DATA}, {2'b01, 4'd3});
        check("push3_ready", 32'(bus.TOKEN_READY), 0);
        tick();
        check("depth1", 32'(bus.DEPTH), 1);
        check("push3_ready_back", 32'(bus.TOKEN_READY), 1);
        push(4'd5);
        check("depth2", 32'(bus.DEPTH), 2);
        send(1'b1, 4'd0);
        check("add_pop_a", 32'(bus.S_COMMAND), 2);
        tick();
        check("add_pop_b", {bus.S_COMMAND, bus.DEPTH}, {2'b10, 3'd1});
        tick();
        check("add_nop", {bus.S_COMMAND, bus.DEPTH}, {2'b00, 3'd0});
        tick();
        check("add_push", {bus.S_COMMAND, bus.S_I_DATA, bus.RESULT_VALID}, {2'b01, 4'd8, 1'b0});
        tick();
        check("add_result", {bus.RESULT_VALID, bus.RESULT, bus.DEPTH, bus.TOKEN_READY}, {1'b1, 4'd8, 3'd1, 1'b1});
        tick();
        check("add_rv_pulse", 32'(bus.RESULT_VALID), 0);
        do_reset();
        push(4'd2);
        push(4'd5);
        op_result(4'd1, 4'd13, "sub");
        push(4'd9);
        push(4'd12);
        op_result(4'd4, 4'd5, "xor");
        tick();
        check("xor_depth", 32'(bus.DEPTH), 2);
        do_reset();
        for (int i = 1; i <= 5; i++) push(4'(i));
        check("full_depth", 32'(bus.DEPTH), 5);
        base = ncmd;
        send(1'b0, 4'd6);
        check("ovf_err", {bus.ERROR, bus.S_COMMAND, bus.TOKEN_READY}, {1'b1, 2'b00, 1'b1});
        tick();
        check("ovf_nopush", ncmd - base, 0);
        check("ovf_depth", 32'(bus.DEPTH), 5);
        op_result(4'd0, 4'd9, "add_after_ovf");
        do_reset();
        check("err_cleared", 32'(bus.ERROR), 0);
        push(4'd7);
        base = ncmd;
        send(1'b1, 4'd0);
        check("unf_err", {bus.ERROR, bus.S_COMMAND, bus.TOKEN_READY}, {1'b1, 2'b00, 1'b1});
        tick();
        tick();
        check("unf_nopop", ncmd - base, 0);
        check("unf_depth", 32'(bus.DEPTH), 1);
        do_reset();
        base = ncmd;
        send(1'b1, 4'd6);
        check("ill_err", 32'(bus.ERROR), 1);
        tick();
        tick();
        check("ill_nocmd", ncmd - base, 0);
        do_reset();
        push(4'd3);
        push(4'd4);
        send(1'b1, 4'd0);
        tick();
        check("mid_in_pop_b", 32'(bus.S_COMMAND), 2);
        RESET = 1'b1;
        tick();
        check("mid_idle", {bus.DEPTH, bus.S_COMMAND}, {3'd0, 2'b00});
        RESET = 1'b0;
        #1;
        check("mid_ready", 32'(bus.TOKEN_READY), 1);
        base = ncmd;
        tick();
        tick();
        tick();
        check("mid_nopush", ncmd - base, 0);
        check("mid_norv", {bus.RESULT_VALID, bus.DEPTH}, {1'b0, 3'd0});
        do_reset();
        push(4'd4);
`ifdef STACK_RPN_DUP_EN
        send(1'b1, 4'd5);
        check("dup_get", {bus.S_COMMAND, bus.S_INDEX}, {2'b11, 3'd0});
        tick();
        check("dup_nop", 32'(bus.S_COMMAND), 0);
        tick();
        check("dup_push", {bus.S_COMMAND, bus.S_I_DATA}, {2'b01, 4'd4});
        tick();
        check("dup_result", {bus.RESULT_VALID, bus.RESULT, bus.DEPTH, bus.ERROR}, {1'b1, 4'd4, 3'd2, 1'b0});
`else
        base = ncmd;
        send(1'b1, 4'd5);
        check("dup_illegal_err", 32'(bus.ERROR), 1);
        tick();
        tick();
        check("dup_illegal_nocmd", ncmd - base, 0);
        check("dup_illegal_depth", 32'(bus.DEPTH), 1);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
